// File: rtl/sfx_arbiter_if.sv
// Sound-effect request/tone bus between game requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface sfx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CODE_W  = 3,
  parameter int DUR_W   = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*CODE_W-1:0] code;
  logic [NUM_REQ*DUR_W-1:0]  dur;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        pending;
  logic                      busy;
  logic [CODE_W-1:0]         sel;
  logic                      en;

  modport master (output req, code, dur, input ack, pending, busy, sel, en);
  modport slave  (input req, code, dur, output ack, pending, busy, sel, en);
endinterface

// File: rtl/sfx_arbiter.sv
// Fixed-priority sharing of one tone generator: latch requests, play for N ticks, silent gap.
// Optional build macro SFX_PREEMPT_EN lets a higher-priority request abort the current tone.
module sfx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CODE_W    = 3,
  parameter int DUR_W     = 8,
  parameter int TICK_DIV  = 100000,
  parameter int GAP_TICKS = 2
) (
  input logic         clk,
  input logic         rst,
  sfx_arbiter_if.slave bus
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_r;
  logic [NUM_REQ-1:0] pending_r;
  logic [CODE_W-1:0]  code_r [NUM_REQ];
  logic [DUR_W-1:0]   dur_r  [NUM_REQ];
  logic [PS_W-1:0]    prescale_r;
  logic [DUR_W-1:0]   remaining_r;
  logic [GAP_W-1:0]   gap_r;
  logic [NUM_REQ-1:0] ack_r;
  logic [CODE_W-1:0]  sel_r;
  logic               en_r;
  logic               busy_r;
`ifdef SFX_PREEMPT_EN
  logic [IDX_W-1:0]   grant_r;
`endif

  logic               tick_s;
  logic               any_s;
  logic [IDX_W-1:0]   lowest_s;
  logic               preempt_s;
  logic               grant_s;
  logic [NUM_REQ-1:0] clr_s;
  logic [NUM_REQ-1:0] pending_nxt_s;

  assign tick_s = (prescale_r == PS_W'(TICK_DIV - 1));

  // Lowest pending index wins; scanning downward leaves the smallest set index.
  always_comb begin
    any_s    = 1'b0;
    lowest_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      any_s    = any_s | pending_r[k];
      lowest_s = pending_r[k] ? IDX_W'(k) : lowest_s;
    end
  end

  // Grant decision and next pending set; a same-cycle re-request keeps its bit set.
  always_comb begin
`ifdef SFX_PREEMPT_EN
    preempt_s = (state_r == PLAY) && any_s && (lowest_s < grant_r);
`else
    preempt_s = 1'b0;
`endif
    grant_s       = ((state_r == IDLE) && any_s) || preempt_s;
    clr_s         = grant_s ? (NUM_REQ'(1) << lowest_s) : '0;
    pending_nxt_s = (pending_r & ~clr_s) | bus.req;
  end

  // Request latch, prescaler and play/gap FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pending_r   <= '0;
      prescale_r  <= '0;
      remaining_r <= '0;
      gap_r       <= '0;
      ack_r       <= '0;
      sel_r       <= '0;
      en_r        <= 1'b0;
      busy_r      <= 1'b0;
`ifdef SFX_PREEMPT_EN
      grant_r     <= '0;
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        code_r[k] <= '0;
        dur_r[k]  <= '0;
      end
    end else begin
      ack_r     <= '0;
      pending_r <= pending_nxt_s;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.req[k]) begin
          code_r[k] <= bus.code[k*CODE_W +: CODE_W];
          dur_r[k]  <= bus.dur[k*DUR_W +: DUR_W];
        end else begin
          code_r[k] <= code_r[k];
          dur_r[k]  <= dur_r[k];
        end
      end

      if (grant_s) begin
        state_r         <= PLAY;
        sel_r           <= code_r[lowest_s];
        remaining_r     <= (dur_r[lowest_s] == '0) ? DUR_W'(1) : dur_r[lowest_s];
        ack_r[lowest_s] <= 1'b1;
        en_r            <= 1'b1;
        busy_r          <= 1'b1;
        prescale_r      <= '0;
`ifdef SFX_PREEMPT_EN
        grant_r         <= lowest_s;
`endif
      end else begin
        prescale_r <= tick_s ? '0 : prescale_r + PS_W'(1);
        case (state_r)
          IDLE: begin
            prescale_r <= '0;
          end
          PLAY: begin
            if (tick_s) begin
              if (remaining_r == DUR_W'(1)) begin
                en_r <= 1'b0;
                if (GAP_TICKS > 0) begin
                  state_r    <= GAP;
                  gap_r      <= GAP_W'(GAP_TICKS);
                  prescale_r <= '0;
                end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                end
              end else begin
                remaining_r <= remaining_r - DUR_W'(1);
              end
            end else begin
              remaining_r <= remaining_r;
            end
          end
          GAP: begin
            if (tick_s) begin
              if (gap_r == GAP_W'(1)) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end else begin
                gap_r <= gap_r - GAP_W'(1);
              end
            end else begin
              gap_r <= gap_r;
            end
          end
          default: begin
            state_r <= IDLE;
            en_r    <= 1'b0;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ack     = ack_r;
  assign bus.pending = pending_r;
  assign bus.busy    = busy_r;
  assign bus.sel     = sel_r;
  assign bus.en      = en_r;

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter with TICK_DIV=4, GAP_TICKS=2, NUM_REQ=4.
// Expected cycle counts are hand-derived from the tone/gap timing.
module tb_sfx_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   n;

  sfx_arbiter_if #(.NUM_REQ(4), .CODE_W(3), .DUR_W(8)) bus ();

  sfx_arbiter #(
    .NUM_REQ(4), .CODE_W(3), .DUR_W(8), .TICK_DIV(4), .GAP_TICKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [2:0] c, input logic [7:0] d);
    bus.code[k*3 +: 3] = c;
    bus.dur[k*8 +: 8]  = d;
  endtask

  // Count consecutive cycles en stays high, starting at the current cycle.
  task automatic count_en(output int cnt);
    cnt = 0;
    while (bus.en && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  // Count consecutive cycles busy stays high, starting at the current cycle.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    checks   = 0;
    errors   = 0;
    bus.req  = 4'b0000;
    bus.code = 12'd0;
    bus.dur  = 32'd0;
    step();
    check_eq("rst_en", {31'd0, bus.en}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_sel", {29'd0, bus.sel}, 32'd0);
    check_eq("rst_pending", {28'd0, bus.pending}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Test 2: single request, dur 3, code 5
    set_slot(2, 3'd5, 8'd3);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    check_eq("t2_pend", {28'd0, bus.pending}, 32'd4);
    check_eq("t2_en_c1", {31'd0, bus.en}, 32'd0);
    step();
    check_eq("t2_ack", {28'd0, bus.ack}, 32'd4);
    check_eq("t2_sel", {29'd0, bus.sel}, 32'd5);
    check_eq("t2_pend_clr", {28'd0, bus.pending}, 32'd0);
    count_en(n);
    check_eq("t2_en_len", n, 32'd12);
    count_busy(n);
    check_eq("t2_gap_len", n, 32'd8);
    check_eq("t2_sel_hold", {29'd0, bus.sel}, 32'd5);

    // Test 3: simultaneous requests 1 and 3
    set_slot(1, 3'd1, 8'd1);
    set_slot(3, 3'd6, 8'd1);
    bus.req = 4'b1010;
    step();
    bus.req = 4'b0000;
    check_eq("t3_pend", {28'd0, bus.pending}, 32'd10);
    step();
    check_eq("t3_ack1", {28'd0, bus.ack}, 32'd2);
    check_eq("t3_sel1", {29'd0, bus.sel}, 32'd1);
    check_eq("t3_pend3", {28'd0, bus.pending}, 32'd8);
    count_en(n);
    check_eq("t3_en1_len", n, 32'd4);
    count_busy(n);
    check_eq("t3_gap_len", n, 32'd8);
    check_eq("t3_idle_ack", {28'd0, bus.ack}, 32'd0);
    step();
    check_eq("t3_ack3", {28'd0, bus.ack}, 32'd8);
    check_eq("t3_sel3", {29'd0, bus.sel}, 32'd6);
    count_en(n);
    check_eq("t3_en3_len", n, 32'd4);
    count_busy(n);

    // Test 4a: zero duration plays one tick
    set_slot(0, 3'd2, 8'd0);
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    step();
    check_eq("t4_ack0", {28'd0, bus.ack}, 32'd1);
    count_en(n);
    check_eq("t4_dur0_len", n, 32'd4);
    count_busy(n);

    // Test 4b: re-request of a pending index overwrites its code
    set_slot(2, 3'd4, 8'd1);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    step();
    check_eq("t4_ack2", {28'd0, bus.ack}, 32'd4);
    set_slot(1, 3'd3, 8'd1);
    bus.req = 4'b0010;
    step();
    set_slot(1, 3'd7, 8'd1);
    step();
    bus.req = 4'b0000;
    check_eq("t4_pend1", {28'd0, bus.pending}, 32'd2);
    n = 0;
    while (bus.ack == 4'b0000 && n < 200) begin
      n++;
      step();
    end
    check_eq("t4_wait_ack", {31'd0, n < 200}, 32'd1);
    check_eq("t4_ack1", {28'd0, bus.ack}, 32'd2);
    check_eq("t4_sel7", {29'd0, bus.sel}, 32'd7);
    count_en(n);
    check_eq("t4_en_len", n, 32'd4);
    count_busy(n);
    step();
    step();
    check_eq("t4_no_replay", {31'd0, bus.busy}, 32'd0);
    check_eq("t4_pend_empty", {28'd0, bus.pending}, 32'd0);

    // Test 5: requester 0 arrives while requester 2 (dur 5) plays
    set_slot(2, 3'd5, 8'd5);
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    step();
    check_eq("t5_ack2", {28'd0, bus.ack}, 32'd4);
    step();
    set_slot(0, 3'd1, 8'd1);
    bus.req = 4'b0001;
    step();
    bus.req = 4'b0000;
    check_eq("t5_pend0", {28'd0, bus.pending}, 32'd1);
`ifdef SFX_PREEMPT_EN
    step();
    check_eq("t5_ack0_pre", {28'd0, bus.ack}, 32'd1);
    check_eq("t5_sel_pre", {29'd0, bus.sel}, 32'd1);
    check_eq("t5_en_pre", {31'd0, bus.en}, 32'd1);
    count_en(n);
    check_eq("t5_en0_len", n, 32'd4);
    count_busy(n);
    step();
    check_eq("t5_no_replay2", {31'd0, bus.busy}, 32'd0);
`else
    count_en(n);
    check_eq("t5_en2_rest", n, 32'd18);
    count_busy(n);
    check_eq("t5_gap_len", n, 32'd8);
    step();
    check_eq("t5_ack0", {28'd0, bus.ack}, 32'd1);
    check_eq("t5_sel0", {29'd0, bus.sel}, 32'd1);
    count_en(n);
    count_busy(n);
`endif

    // Test 6: request lands on the last PLAY tick
    set_slot(1, 3'd2, 8'd1);
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    step();
    check_eq("t6_ack1", {28'd0, bus.ack}, 32'd2);
    step();
    step();
    step();
    set_slot(3, 3'd3, 8'd1);
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0000;
    check_eq("t6_en_off", {31'd0, bus.en}, 32'd0);
    check_eq("t6_pend3", {28'd0, bus.pending}, 32'd8);
    count_busy(n);
    check_eq("t6_gap_len", n, 32'd8);
    step();
    check_eq("t6_ack3", {28'd0, bus.ack}, 32'd8);
    check_eq("t6_sel3", {29'd0, bus.sel}, 32'd3);
    step();
    check_eq("t6_ack_once", {28'd0, bus.ack}, 32'd0);
    count_busy(n);

    // Test 1: reset asserted mid-PLAY while another request is pending
    set_slot(1, 3'd4, 8'd3);
    set_slot(3, 3'd5, 8'd1);
    bus.req = 4'b1010;
    step();
    bus.req = 4'b0000;
    step();
    check_eq("t1_ack_pre", {28'd0, bus.ack}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t1_en", {31'd0, bus.en}, 32'd0);
    check_eq("t1_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t1_sel", {29'd0, bus.sel}, 32'd0);
    check_eq("t1_ack", {28'd0, bus.ack}, 32'd0);
    check_eq("t1_pend", {28'd0, bus.pending}, 32'd0);
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    step();
    step();
    check_eq("t1_post_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("t1_post_ack", {28'd0, bus.ack}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
